// File: rtl/pokey_kbd_irq.sv
// POKEY keyboard interrupt block: synchronises the key scanner, debounces CONFIRM,
// and maintains KBCODE, keyboard SKSTAT bits, KEY/BREAK IRQST bits and the IRQ line.
module pokey_kbd_irq #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk179,
  input  logic       rst,
  input  logic [1:0] key_state,
  input  logic [3:0] keycode,
  input  logic       shift_L,
  input  logic       ctrl_L,
  input  logic       break_L,
  input  logic       irqen_wr,
  input  logic       skres_wr,
  input  logic [7:0] data_in,
  output logic [7:0] kbcode,
  output logic [2:0] skstat_kbd,
  output logic [1:0] irqst_kbd,
  output logic       irq_L
);

  localparam logic [1:0] ST_UP   = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  localparam logic [1:0] KS_IDLE    = 2'b00;
  localparam logic [1:0] KS_CONFIRM = 2'b10;
  localparam logic [7:0] CNT_DONE   = 8'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][8:0] r_sync;
  logic                        r_brk_prev;
  logic [1:0]                  r_state;
  logic [7:0]                  r_cnt;
  logic [1:0]                  r_irqen;

  logic [8:0] w_async;
  logic [1:0] w_ks_s;
  logic [3:0] w_kc_s;
  logic       w_sh_s;
  logic       w_ct_s;
  logic       w_bk_s;
  logic       w_brk_fall;
  logic [1:0] w_state_next;
  logic [7:0] w_cnt_next;
  logic       w_key_evt;
  logic [1:0] w_irqst_next;
  logic       w_ovr_next;

  assign w_async    = {key_state, keycode, shift_L, ctrl_L, break_L};
  assign w_ks_s     = r_sync[SYNC_STAGES-1][8:7];
  assign w_kc_s     = r_sync[SYNC_STAGES-1][6:3];
  assign w_sh_s     = r_sync[SYNC_STAGES-1][2];
  assign w_ct_s     = r_sync[SYNC_STAGES-1][1];
  assign w_bk_s     = r_sync[SYNC_STAGES-1][0];
  assign w_brk_fall = r_brk_prev & ~w_bk_s;

  // Synchronisers and break edge history run free so reset does not restart them.
  always_ff @(posedge clk179) begin
    r_sync[0] <= w_async;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      r_sync[i] <= r_sync[i-1];
    end
    r_brk_prev <= w_bk_s;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_key_evt    = 1'b0;
    case (r_state)
      ST_UP: begin
        if (w_ks_s == KS_CONFIRM) begin
          w_cnt_next = 8'd1;
          if (CNT_DONE == 8'd1) begin
            w_state_next = ST_DOWN;
            w_key_evt    = 1'b1;
          end else begin
            w_state_next = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (w_ks_s == KS_CONFIRM) begin
          w_cnt_next = r_cnt + 8'd1;
          if (w_cnt_next == CNT_DONE) begin
            w_state_next = ST_DOWN;
            w_key_evt    = 1'b1;
          end
        end else begin
          w_state_next = ST_UP;
          w_cnt_next   = '0;
        end
      end
      ST_DOWN: begin
        if (w_ks_s == KS_IDLE) begin
          w_state_next = ST_UP;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_UP;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Priority: SKRES < overrun, and an IRQEN clear beats any same-edge event.
  always_comb begin
    w_irqst_next = irqst_kbd;
    w_ovr_next   = skstat_kbd[2];
    if (skres_wr) w_ovr_next = 1'b1;
    if (w_key_evt && r_irqen[0]) begin
      if (!irqst_kbd[0]) w_ovr_next      = 1'b0;
      else               w_irqst_next[0] = 1'b0;
    end
    if (w_brk_fall && r_irqen[1]) w_irqst_next[1] = 1'b0;
    if (irqen_wr) begin
      if (!data_in[6]) w_irqst_next[0] = 1'b1;
      if (!data_in[7]) w_irqst_next[1] = 1'b1;
    end
  end

  always_ff @(posedge clk179) begin
    if (rst) begin
      r_state    <= ST_UP;
      r_cnt      <= '0;
      r_irqen    <= '0;
      kbcode     <= '0;
      skstat_kbd <= '1;
      irqst_kbd  <= '1;
      irq_L      <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      if (irqen_wr) r_irqen <= data_in[7:6];
      if (w_key_evt) kbcode <= {~w_ct_s, ~w_sh_s, 2'b00, w_kc_s};
      skstat_kbd <= {w_ovr_next, w_sh_s, (w_state_next == ST_UP)};
      irqst_kbd  <= w_irqst_next;
      irq_L      <= &irqst_kbd;
    end
  end

endmodule

// File: tb/tb_pokey_kbd_irq.sv
// Scoreboard bench for pokey_kbd_irq: a press/break reference model predicts every
// cycle's outputs into a queue which an independent monitor drains and compares.
module tb_pokey_kbd_irq;

  localparam int unsigned S = 2;
  localparam int unsigned D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ks;
  logic [3:0] kc;
  logic       sh, ct, bk, iw, sw;
  logic [7:0] din;
  logic [7:0] kbcode;
  logic [2:0] skstat_kbd;
  logic [1:0] irqst_kbd;
  logic       irq_L;

  pokey_kbd_irq #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk179(clk), .rst(rst), .key_state(ks), .keycode(kc),
    .shift_L(sh), .ctrl_L(ct), .break_L(bk), .irqen_wr(iw), .skres_wr(sw),
    .data_in(din), .kbcode(kbcode), .skstat_kbd(skstat_kbd),
    .irqst_kbd(irqst_kbd), .irq_L(irq_L)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] kb;
    logic [2:0] sk;
    logic [1:0] iq;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: inputs seen through the synchroniser delay line,
  // how long the current CONFIRM run has lasted, and whether a key is held.
  logic [8:0]  m_sync[$];
  int unsigned m_run;
  bit          m_held;
  bit          m_bk_prev;
  logic [1:0]  m_en;
  logic [7:0]  m_kb;
  logic        m_ovr, m_sh, m_kd, m_irq;
  logic [1:0]  m_iq;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic model_push();
    logic [8:0] s;
    bit         key_evt, bk_fall;
    logic [1:0] old_iq;
    s = m_sync[$];
    void'(m_sync.pop_back());
    m_sync.push_front({ks, kc, sh, ct, bk});
    bk_fall   = m_bk_prev && !s[0];
    m_bk_prev = s[0];
    if (rst) begin
      m_run = 0; m_held = 0; m_en = 2'b00;
      m_kb = 8'h00; m_ovr = 1; m_sh = 1; m_kd = 1; m_iq = 2'b11; m_irq = 1;
    end else begin
      key_evt = 0;
      if (m_held) begin
        if (s[8:7] == 2'b00) m_held = 0;
      end else if (s[8:7] == 2'b10) begin
        m_run++;
        if (m_run == D) begin
          m_held = 1; m_run = 0; key_evt = 1;
        end
      end else begin
        m_run = 0;
      end
      old_iq = m_iq;
      m_irq  = old_iq[1] & old_iq[0];
      if (key_evt) m_kb = {~s[1], ~s[2], 2'b00, s[6:3]};
      if (sw) m_ovr = 1;
      if (key_evt && m_en[0]) begin
        if (old_iq[0] == 1'b0) m_ovr = 0;
        else m_iq[0] = 0;
      end
      if (bk_fall && m_en[1]) m_iq[1] = 0;
      if (iw) begin
        if (!din[6]) m_iq[0] = 1;
        if (!din[7]) m_iq[1] = 1;
        m_en = din[7:6];
      end
      m_sh = s[2];
      m_kd = !(m_held || m_run > 0);
    end
    sb.push_back('{m_kb, {m_ovr, m_sh, m_kd}, m_iq, m_irq});
  endtask

  // Predict the outcome of the coming edge, then wait out the cycle.
  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      model_push();
      @(negedge clk);
      iw = 0; sw = 0;
    end
  endtask

  task automatic write_irqen(logic [7:0] d);
    iw = 1; din = d;
    step();
  endtask

  // Monitor: every edge presents a full output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("kbcode",     int'(kbcode),     int'(e.kb));
        check("skstat_kbd", int'(skstat_kbd), int'(e.sk));
        check("irqst_kbd",  int'(irqst_kbd),  int'(e.iq));
        check("irq_L",      int'(irq_L),      int'(e.irq));
      end
    end
  end

  initial begin
    for (int i = 0; i < S; i++) m_sync.push_back(9'b00_0000_111);
    m_bk_prev = 1; m_run = 0; m_held = 0; m_en = 0;
    m_kb = 0; m_ovr = 1; m_sh = 1; m_kd = 1; m_iq = 2'b11; m_irq = 1;
    rst = 1; ks = 2'b00; kc = 4'h0; sh = 1; ct = 1; bk = 1; iw = 0; sw = 0; din = 8'h00;
    step(4);
    rst = 0;
    step(2);
    check("reset_kbcode", int'(kbcode), 8'h00);
    check("reset_irqst", int'(irqst_kbd), 2'b11);

    // Enable and press
    write_irqen(8'hC0);
    ks = 2'b10; kc = 4'h5; sh = 0; ct = 1;
    step(20);
    check("press_kbcode", int'(kbcode), 8'h45);
    check("press_irqst", int'(irqst_kbd), 2'b10);
    check("press_irq_L", int'(irq_L), 0);
    ks = 2'b00; step(6);

    // Bounce shorter than the debounce window
    ks = 2'b10; kc = 4'h7; step(5);
    ks = 2'b00; step(6);
    check("bounce_kbcode", int'(kbcode), 8'h45);

    // Overrun while KEY still pending, then SKRES and IRQEN clear
    sh = 1; ks = 2'b10; kc = 4'hA; step(15);
    check("ovr_kbcode", int'(kbcode), 8'h0A);
    check("ovr_bit5", int'(skstat_kbd[2]), 0);
    ks = 2'b00; step(4);
    sw = 1; step(2);
    check("skres_bit5", int'(skstat_kbd[2]), 1);
    write_irqen(8'h80);
    step(1);
    check("clr_irq_L", int'(irq_L), 1);

    // Masked key
    write_irqen(8'h00);
    ks = 2'b10; kc = 4'h3; step(15);
    check("mask_kbcode", int'(kbcode), 8'h03);
    check("mask_irqst", int'(irqst_kbd), 2'b11);
    ks = 2'b00; step(4);

    // Break held low, then a clear coinciding with a second synced falling edge
    write_irqen(8'h80);
    bk = 0; step(50);
    check("brk_irqst", int'(irqst_kbd), 2'b01);
    bk = 1; step(3);
    write_irqen(8'h00);
    write_irqen(8'h80);
    bk = 0; step(2);
    write_irqen(8'h00);
    step(3);
    check("brk_clear_wins", int'(irqst_kbd[1]), 1);
    bk = 1; step(3);

    // Reset while the key is down and the scanner stays in CONFIRM
    write_irqen(8'hC0);
    ks = 2'b10; kc = 4'h9; step(14);
    rst = 1; step(1);
    rst = 0;
    check("rst_kbcode", int'(kbcode), 8'h00);
    write_irqen(8'hC0);
    step(14);
    check("rst_new_evt", int'(kbcode), 8'h09);
    ks = 2'b00; step(4);

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: ks = 2'b00;
          1: ks = 2'b01;
          default: ks = 2'b10;
        endcase
        kc = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) sh = ~sh;
      if ($urandom_range(0, 7) == 0) ct = ~ct;
      if ($urandom_range(0, 11) == 0) bk = ~bk;
      if ($urandom_range(0, 39) == 0) begin
        iw = 1; din = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 29) == 0) sw = 1;
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 0;
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
